// File: rtl/pattern_detector_pkg.sv
// Shared defaults, length-width helper and match-mode encoding for the programmable pattern detector.
package pattern_detector_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } mode_e;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/pd_window.sv
// Serial history window with a saturating count of valid bits received since the last clear.
module pd_window #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic               data_i,
  input  logic               restart_i,
  output logic [MAX_LEN-1:0] window_next_o,
  output logic [LEN_W-1:0]   fill_o
);

  logic [MAX_LEN-1:0] r_window;
  logic [LEN_W-1:0]   r_fill;

  assign window_next_o = {r_window[MAX_LEN-2:0], data_i};
  assign fill_o        = r_fill;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_window <= '0;
      r_fill   <= '0;
    end else if (shift_i) begin
      r_window <= window_next_o;
      // restart lets the owner demand a fresh run of bits after a non-overlapping match
      if (restart_i)
        r_fill <= '0;
      else if (r_fill != LEN_W'(MAX_LEN))
        r_fill <= r_fill + LEN_W'(1);
    end
  end

endmodule

// File: rtl/pattern_detector_prog.sv
// Programmable-length serial pattern detector with overlap mode and saturating match counter.
// Optional per-bit compare mask enabled by defining PATTERN_MASK_EN.
module pattern_detector_prog
  import pattern_detector_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = len_w(MAX_LEN),
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               data_i,
  input  logic               valid_i,
  input  logic               pat_load_i,
  input  logic [MAX_LEN-1:0] pat_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               overlap_i,
`ifdef PATTERN_MASK_EN
  input  logic [MAX_LEN-1:0] mask_i,
`endif
  output logic               match_o,
  output logic [CNT_W-1:0]   match_cnt_o,
  output logic               armed_o
);

  localparam logic [MAX_LEN:0] L_ONE   = {{MAX_LEN{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  mode_e              r_mode;
  logic               r_armed;
  logic               r_match;
  logic [CNT_W-1:0]   r_cnt;
`ifdef PATTERN_MASK_EN
  logic [MAX_LEN-1:0] r_mask;
`endif

  logic [MAX_LEN-1:0] w_window_next;
  logic [LEN_W-1:0]   w_fill;
  logic [LEN_W-1:0]   w_eff_len;
  logic [MAX_LEN:0]   w_lenmask_wide;
  logic [MAX_LEN-1:0] w_cmpmask;
  logic               w_fill_ok;
  logic               w_hit;
  logic               w_restart;

  pd_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .clear_i       (pat_load_i),
    .shift_i       (valid_i),
    .data_i        (data_i),
    .restart_i     (w_restart),
    .window_next_o (w_window_next),
    .fill_o        (w_fill)
  );

  assign w_eff_len = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;

  // Extra top bit keeps the shift well defined when the length equals MAX_LEN
  assign w_lenmask_wide = (L_ONE << r_len) - L_ONE;

`ifdef PATTERN_MASK_EN
  assign w_cmpmask = w_lenmask_wide[MAX_LEN-1:0] & r_mask;
`else
  assign w_cmpmask = w_lenmask_wide[MAX_LEN-1:0];
`endif

  assign w_fill_ok = ({1'b0, w_fill} + (LEN_W+1)'(1)) >= {1'b0, r_len};
  assign w_hit     = r_armed & valid_i & ~pat_load_i & w_fill_ok &
                     (((w_window_next ^ r_pat) & w_cmpmask) == '0);
  assign w_restart = w_hit & (r_mode == MODE_NONOVL);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pat   <= '0;
      r_len   <= '0;
      r_mode  <= MODE_NONOVL;
      r_armed <= 1'b0;
      r_match <= 1'b0;
      r_cnt   <= '0;
`ifdef PATTERN_MASK_EN
      r_mask  <= '0;
`endif
    end else if (pat_load_i) begin
      r_pat   <= pat_i;
      r_len   <= w_eff_len;
      r_mode  <= mode_e'(overlap_i);
      r_armed <= (w_eff_len != '0);
      r_match <= 1'b0;
      r_cnt   <= '0;
`ifdef PATTERN_MASK_EN
      r_mask  <= mask_i;
`endif
    end else begin
      r_match <= w_hit;
      if (w_hit && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match_o     = r_match;
  assign match_cnt_o = r_cnt;
  assign armed_o     = r_armed;

endmodule

// File: tb/tb_pattern_detector_prog.sv
// Scoreboard bench for pattern_detector_prog: directed scenarios plus random traffic vs. a bit-history model.
module tb_pattern_detector_prog;
  import pattern_detector_pkg::*;

  localparam int ML = 8;
  localparam int LW = len_w(ML);
  localparam int CW = 8;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          data_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          pat_load_i = 1'b0;
  logic [ML-1:0] pat_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          overlap_i = 1'b0;
`ifdef PATTERN_MASK_EN
  logic [ML-1:0] mask_i = '1;
`endif
  logic          match_o;
  logic [CW-1:0] match_cnt_o;
  logic          armed_o;

  always #5 clk_i = ~clk_i;

  pattern_detector_prog #(.MAX_LEN(ML), .LEN_W(LW), .CNT_W(CW)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .pat_load_i  (pat_load_i),
    .pat_i       (pat_i),
    .len_i       (len_i),
    .overlap_i   (overlap_i),
`ifdef PATTERN_MASK_EN
    .mask_i      (mask_i),
`endif
    .match_o     (match_o),
    .match_cnt_o (match_cnt_o),
    .armed_o     (armed_o)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit m;
    int cnt;
    bit armed;
  } exp_t;
  exp_t q[$];

  // reference model: recent received bits, pattern settings, bits since last clear/restart
  bit          hist[$];
  int          since = 0;
  int          m_cnt = 0;
  int          m_len = 0;
  bit          m_armed = 0;
  bit          m_ovl = 0;
  bit [ML-1:0] m_pat = '0;
  bit [ML-1:0] m_mask = '1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit ld, input bit v, input bit d,
                      input logic [ML-1:0] p, input int len, input bit ovl,
                      input logic [ML-1:0] mk);
    exp_t e;
    bit   hit;
    @(negedge clk_i);
    reset_i    = rst;
    pat_load_i = ld;
    valid_i    = v;
    data_i     = d;
    pat_i      = p;
    len_i      = LW'(len);
    overlap_i  = ovl;
`ifdef PATTERN_MASK_EN
    mask_i     = mk;
`endif
    hit = 0;
    if (rst) begin
      hist.delete(); since = 0; m_cnt = 0; m_len = 0; m_armed = 0; m_ovl = 0; m_pat = '0;
    end else if (ld) begin
      m_pat = p;
      m_len = (len > ML) ? ML : len;
      m_armed = (m_len != 0);
      m_ovl = ovl;
`ifdef PATTERN_MASK_EN
      m_mask = mk;
`else
      m_mask = '1;
`endif
      hist.delete(); since = 0; m_cnt = 0;
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() > ML) void'(hist.pop_front());
      since++;
      if (m_armed && since >= m_len) begin
        hit = 1;
        for (int i = 0; i < m_len; i++)
          if (m_mask[i] && (hist[hist.size()-1-i] != m_pat[i])) hit = 0;
      end
      if (hit) begin
        if (m_cnt < CNT_SAT) m_cnt++;
        if (!m_ovl) since = 0;
      end
    end
    e.m = hit; e.cnt = m_cnt; e.armed = m_armed;
    q.push_back(e);
  endtask

  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("match_o", 32'(match_o), 32'(e.m));
      chk("match_cnt_o", 32'(match_cnt_o), 32'(e.cnt));
      chk("armed_o", 32'(armed_o), 32'(e.armed));
    end
  end

  task automatic do_reset();
    step(1, 0, 0, 0, '0, 0, 0, '1);
  endtask

  task automatic load(input logic [ML-1:0] p, input int len, input bit ovl, input logic [ML-1:0] mk);
    step(0, 1, 0, 0, p, len, ovl, mk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, 0, 0, '1);
  endtask

  // feed n bits of b, most significant first; gap inserts one bubble after each bit
  task automatic feed(input logic [31:0] b, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(0, 0, 1, b[i], '0, 0, 0, '1);
      if (gap) idle();
    end
  endtask

  task automatic check_cnt(input string name, input int exp_cnt);
    @(posedge clk_i);
    #2;
    chk(name, 32'(match_cnt_o), 32'(exp_cnt));
  endtask

  initial begin
    do_reset();
    check_cnt("reset_cnt", 0);
    chk("reset_armed", 32'(armed_o), 0);

    load(8'b1011, 4, 1, '1);
    feed(32'b0100101101, 10, 0);
    check_cnt("p1011_stream", 1);

    load(8'b101, 3, 1, '1);
    feed(32'b0100101101, 10, 0);
    check_cnt("p101_stream", 2);

    load(8'b101, 3, 1, '1);
    feed(32'b10101, 5, 0);
    check_cnt("p101_overlap", 2);

    load(8'b101, 3, 0, '1);
    feed(32'b10101, 5, 0);
    check_cnt("p101_nonoverlap", 1);

    load(8'b1011, 4, 1, '1);
    feed(32'b1011, 4, 1);
    check_cnt("bubbles", 1);

    load(8'b0, 0, 1, '1);
    feed(32'b0000_1111_0101_1010, 16, 0);
    check_cnt("len0_cnt", 0);
    chk("len0_armed", 32'(armed_o), 0);

    load(8'hA5, 15, 0, '1);
    feed(32'b1010_0101, 8, 0);
    check_cnt("len15_clamp", 1);

    load(8'b1011, 4, 1, '1);
    feed(32'b101, 3, 0);
    do_reset();
    feed(32'b1, 1, 0);
    check_cnt("mid_reset_cnt", 0);
    chk("mid_reset_armed", 32'(armed_o), 0);

    step(0, 1, 1, 1, 8'b1, 1, 1, '1);
    idle();
    check_cnt("load_drops_bit", 0);
    feed(32'b1, 1, 0);
    check_cnt("len1_hit", 1);

    load(8'b1, 1, 1, '1);
    for (int i = 0; i < CNT_SAT + 5; i++) feed(32'b1, 1, 0);
    check_cnt("cnt_saturate", CNT_SAT);

`ifdef PATTERN_MASK_EN
    load(8'b1011, 4, 1, 8'b1101);
    feed(32'b1001, 4, 0);
    check_cnt("mask_1001", 1);
    load(8'b1011, 4, 1, 8'b1101);
    feed(32'b1011, 4, 0);
    check_cnt("mask_1011", 1);
    load(8'b1011, 4, 1, 8'b0);
    feed(32'b0000, 4, 0);
    check_cnt("mask_zero", 1);
`endif

    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        do_reset();
      end else if (r < 5) begin
        int len;
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 3);
        step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1), ML'($urandom),
             len, $urandom_range(0, 1), ML'($urandom));
      end else begin
        step(0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1), ML'($urandom),
             $urandom_range(0, 15), $urandom_range(0, 1), ML'($urandom));
      end
    end

    idle();
    idle();
    @(posedge clk_i);
    #3;
    chk("queue_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_detector_prog.md
Name: pattern_detector_prog

Overview:
Parametrised successor to the fixed serial pattern detector. Watches a 1-bit serial stream qualified by a valid strobe and flags each occurrence of a runtime-loaded pattern of programmable length (1..MAX_LEN). Supports overlapping and non-overlapping match modes and keeps a saturating match counter. Sits on the serial data path ahead of the frame/sync logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, $clog2(MAX_LEN+1), width of the length field
CNT_W, 8, width of the match counter

Ports:
clk_i  in  1  single clock, rising edge
reset_i  in  1  synchronous reset, active-high
data_i  in  1  serial data bit
valid_i  in  1  data_i is sampled only when high
pat_load_i  in  1  load pat_i, len_i and overlap_i this cycle
pat_i  in  MAX_LEN  pattern; pat_i[len-1] is the first-received bit, pat_i[0] the last
len_i  in  LEN_W  pattern length
overlap_i  in  1  1 = overlapping matches, 0 = non-overlapping
match_o  out  1  one-cycle pulse per detected match
match_cnt_o  out  CNT_W  saturating count of matches
armed_o  out  1  a valid pattern (len 1..MAX_LEN) is loaded

Behaviour:
- Reset (clk_i edge with reset_i=1): window, fill, pattern, len, mode, match_o, match_cnt_o and armed_o all 0. Reset overrides every other input. Reset mid-stream discards all partial history.
- Window: MAX_LEN shift register. On valid_i=1, shifts left with data_i entering bit 0. Fill counter counts valid bits received and saturates at MAX_LEN.
- Load: pat_load_i=1 latches pat_i, eff_len and overlap_i, then clears window, fill, match_cnt_o and match_o. eff_len = MAX_LEN if len_i > MAX_LEN, else len_i. armed_o = (eff_len != 0), registered, visible the cycle after load. When load and valid occur in the same cycle, load wins and the data bit is discarded.
- Match condition, evaluated on the shifted-in window: armed, valid_i=1, (fill+1) >= eff_len, and window_next[eff_len-1:0] == pat[eff_len-1:0].
- Latency: match_o is registered. It goes high for exactly one cycle after the edge that samples the completing bit, and is 0 in all other cycles, including valid_i=0 cycles.
- Overlap mode: the fill counter continues after a match, so a single bit can end consecutive matches.
- Non-overlap mode: on a match, the fill counter is set to 0. The next match needs eff_len new valid bits.
- Counter: increments on each match and holds at 2^CNT_W-1.
- With armed_o=0, no matches occur; the window still shifts.
- Bubbles: valid_i=0 cycles leave window, fill and counter unchanged.

Optional Feature:
Macro PATTERN_MASK_EN.
- Defined: adds port mask_i (in, MAX_LEN), latched on pat_load_i. The comparison ignores bit positions where the mask bit is 0, i.e. ((window_next ^ pat) & mask & lenmask) == 0. An all-zero mask matches as soon as the fill requirement is met.
- Undefined: no port, and all eff_len bits are compared.

Decomposition:
- Package pattern_detector_pkg holds MAX_LEN and CNT_W defaults, the LEN_W function, and a mode enum (MODE_NONOVL=0, MODE_OVL=1).
- One sub-module, pd_window: shift register plus saturating fill counter with a clear input.
- Compare, match and counter logic stay in the top level.

Test Plan:
- Load pat=4'b1011, len=4, overlap=1. Feed 0,1,0,0,1,0,1,1,0,1 with valid=1 → one match_o pulse, the cycle after bit 8. match_cnt_o=1.
- Load pat=3'b101, len=3, overlap=1. Feed the same stream → pulses after bits 7 and 10. match_cnt_o=2.
- Feed 1,0,1,0,1 with pat=101, len=3. With overlap=1 → pulses after bits 3 and 5, count 2. With overlap=0 → pulse after bit 3 only, count 1.
- Pat=1011, len=4. Insert valid=0 bubbles between every bit of 1,0,1,1 → exactly one pulse after the last valid bit, and no pulse during bubbles.
- Misc cases:
  - len_i=0 → armed_o=0 and no pulses on any stream.
  - len_i=15 with MAX_LEN=8 → eff_len=8.
  - Assert reset_i after 3 bits of 1011 → outputs 0, and a subsequent 1 does not match.
  - Load with valid in the same cycle → bit dropped.
- Count saturation, CNT_W=2, pat=1, len=1, overlap=1: feed five 1s → match_cnt_o reads 1,2,3,3,3.
- With PATTERN_MASK_EN, pat=1011, mask=1101: stream 1,0,0,1 and stream 1,0,1,1 each produce one pulse.
